// File: rtl/tcp_slot_ctrl_pkg.sv
// tcp_slot_ctrl_pkg
//   Shared definitions for the TCP connection-slot manager: command op
//   codes, response error codes, controller FSM states and the 96-bit
//   TCP 4-tuple layout used by the controller and its slot entries.
package tcp_slot_ctrl_pkg;

    localparam int unsigned TUPLE_W = 96;

    typedef enum logic [1:0] {
        OP_ADD   = 2'd0,
        OP_DEL   = 2'd1,
        OP_FLUSH = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_DUP      = 2'd1,
        ERR_FULL     = 2'd2,
        ERR_NOTFOUND = 2'd3
    } err_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SCAN    = 3'd1,
        ST_WAITGAP = 3'd2,
        ST_COMMIT  = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

    // Field order fixes the packed 96-bit layout, src_ip in the MSBs.
    typedef struct packed {
        logic [31:0] src_ip;
        logic [15:0] src_port;
        logic [31:0] dst_ip;
        logic [15:0] dst_port;
    } tuple_t;

endpackage

// File: rtl/tcp_slot_ctrl_if.sv
// tcp_slot_ctrl_if
//   Host command/response channel of tcp_slot_ctrl.
//   cmd_valid/cmd_ready  : command handshake (accepted when both high)
//   cmd_op               : 0=ADD 1=DEL 2=FLUSH 3=reserved
//   cmd_src_ip/port, cmd_dst_ip/port : command tuple
//   rsp_valid            : one-cycle response pulse
//   rsp_slot, rsp_err    : slot affected, 0=ok 1=dup 2=full 3=not found
//   master = host side, slave = controller side.
interface tcp_slot_ctrl_if #(
    parameter int unsigned IDX_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [31:0]      cmd_src_ip;
    logic [15:0]      cmd_src_port;
    logic [31:0]      cmd_dst_ip;
    logic [15:0]      cmd_dst_port;
    logic             rsp_valid;
    logic [IDX_W-1:0] rsp_slot;
    logic [1:0]       rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_src_ip, cmd_src_port, cmd_dst_ip, cmd_dst_port,
        input  cmd_ready, rsp_valid, rsp_slot, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_src_ip, cmd_src_port, cmd_dst_ip, cmd_dst_port,
        output cmd_ready, rsp_valid, rsp_slot, rsp_err
    );
endinterface

// File: rtl/tcp_slot_ctrl_entry.sv
// tcp_slot_entry
//   One filter slot: live flag, stored tuple and (with TCP_SLOT_HITCNT_EN)
//   a 16-bit saturating match counter.
//   CLOCK, RESET : clock, synchronous active-high reset
//   wr_en        : load wr_tuple and mark the slot live
//   clr_en       : drop the slot and zero its tuple (wins over wr_en)
//   cmp_tuple    : tuple compared against the stored one
//   en, tuple    : current slot state
//   hit          : slot is live and stored tuple equals cmp_tuple
//   match_in     : (TCP_SLOT_HITCNT_EN) filter match strobe for this slot
//   cnt_clr      : (TCP_SLOT_HITCNT_EN) clear the counter
//   hit_cnt      : (TCP_SLOT_HITCNT_EN) saturating match count
module tcp_slot_entry
    import tcp_slot_ctrl_pkg::*;
(
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               wr_en,
    input  logic               clr_en,
    input  logic [TUPLE_W-1:0] wr_tuple,
    input  logic [TUPLE_W-1:0] cmp_tuple,
    output logic               en,
    output logic [TUPLE_W-1:0] tuple,
    output logic               hit
`ifdef TCP_SLOT_HITCNT_EN
    ,
    input  logic               match_in,
    input  logic               cnt_clr,
    output logic [15:0]        hit_cnt
`endif
);

    always_ff @(posedge CLOCK) begin
        if (RESET || clr_en) begin
            en    <= 1'b0;
            tuple <= '0;
        end else if (wr_en) begin
            en    <= 1'b1;
            tuple <= wr_tuple;
        end
    end

    assign hit = en && (tuple == cmp_tuple);

`ifdef TCP_SLOT_HITCNT_EN
    always_ff @(posedge CLOCK) begin
        if (RESET || cnt_clr) begin
            hit_cnt <= '0;
        end else if (match_in && (hit_cnt != '1)) begin
            hit_cnt <= hit_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: rtl/tcp_slot_ctrl.sv
// tcp_slot_ctrl
//   Connection-slot manager for the TCP payload filter. Holds SLOTS TCP
//   4-tuples and drives them to the filter slots. Host ADD/DEL/FLUSH
//   commands are scanned one slot per cycle, then committed only in an
//   inter-packet gap (dataValid==0 && newpkt==0) so a filter never sees a
//   tuple change mid-packet.
//   Optional feature macro: TCP_SLOT_HITCNT_EN (per-slot match counters,
//   adds slot_match input and rsp_hits output).
// Ports:
//   CLOCK, RESET      : clock, synchronous active-high reset
//   host              : command/response channel (tcp_slot_ctrl_if.slave)
//   dataValid, newpkt : parser byte strobe / start-of-packet pulse
//   slot_en           : per-slot live flag
//   slot_src_ip, slot_src_port, slot_dst_ip, slot_dst_port :
//                       per-slot tuple fields, slot i in the i-th field lane
//   slot_match        : (TCP_SLOT_HITCNT_EN) per-slot filter match strobe
//   rsp_hits          : (TCP_SLOT_HITCNT_EN) deleted slot's count on DEL
module tcp_slot_ctrl
    import tcp_slot_ctrl_pkg::*;
#(
    parameter int unsigned SLOTS = 2,
    parameter int unsigned IDX_W = 3
) (
    input  logic                CLOCK,
    input  logic                RESET,
    tcp_slot_ctrl_if.slave      host,
    input  logic                dataValid,
    input  logic                newpkt,
    output logic [SLOTS-1:0]    slot_en,
    output logic [SLOTS*32-1:0] slot_src_ip,
    output logic [SLOTS*16-1:0] slot_src_port,
    output logic [SLOTS*32-1:0] slot_dst_ip,
    output logic [SLOTS*16-1:0] slot_dst_port
`ifdef TCP_SLOT_HITCNT_EN
    ,
    input  logic [SLOTS-1:0]    slot_match,
    output logic [15:0]         rsp_hits
`endif
);

    state_e           state_q, state_d;
    op_e              op_q;
    tuple_t           tup_q;
    tuple_t           cmd_tuple;
    logic [IDX_W-1:0] scan_idx_q;
    logic             free_found_q, match_found_q;
    logic [IDX_W-1:0] free_idx_q, match_idx_q;
    logic [IDX_W-1:0] rsp_slot_q;
    err_e             rsp_err_q;

    logic             gap, accept, ready, commit, last;
    logic             cur_en, cur_hit;
    logic             free_now, match_now;
    logic [IDX_W-1:0] free_idx_now, match_idx_now;
    logic             rsp_load;
    logic [IDX_W-1:0] rsp_slot_d;
    err_e             rsp_err_d;

    logic [SLOTS-1:0] ent_en, ent_hit;
    tuple_t           ent_tuple [SLOTS];

    assign gap       = !dataValid && !newpkt;
    assign accept    = host.cmd_valid && host.cmd_ready;
    assign cmd_tuple = {host.cmd_src_ip, host.cmd_src_port, host.cmd_dst_ip, host.cmd_dst_port};
    assign last      = (scan_idx_q == IDX_W'(SLOTS - 1));

    // Slot currently visited by the scan.
    always_comb begin
        cur_en  = 1'b0;
        cur_hit = 1'b0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (scan_idx_q == IDX_W'(i)) begin
                cur_en  = ent_en[i];
                cur_hit = ent_hit[i];
            end
        end
    end

    // Lowest-index results including the slot visited this cycle.
    assign free_now      = free_found_q || !cur_en;
    assign free_idx_now  = free_found_q ? free_idx_q : scan_idx_q;
    assign match_now     = match_found_q || cur_hit;
    assign match_idx_now = match_found_q ? match_idx_q : scan_idx_q;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Gap lookahead: the cycle that leaves IDLE (FLUSH) or the last SCAN
    // cycle already counts as the first WAITGAP cycle, so a command issued
    // in a gap commits without spending a separate cycle in WAITGAP.
    always_comb begin
        state_d    = state_q;
        ready      = 1'b0;
        commit     = 1'b0;
        rsp_load   = 1'b0;
        rsp_slot_d = '0;
        rsp_err_d  = ERR_OK;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (host.cmd_valid) begin
                    case (host.cmd_op)
                        OP_ADD, OP_DEL: begin
                            state_d = ST_SCAN;
                        end
                        OP_FLUSH: begin
                            rsp_load = 1'b1;
                            state_d  = gap ? ST_COMMIT : ST_WAITGAP;
                        end
                        default: begin
                            rsp_load  = 1'b1;
                            rsp_err_d = ERR_NOTFOUND;
                            state_d   = ST_RESP;
                        end
                    endcase
                end
            end
            ST_SCAN: begin
                if (last) begin
                    rsp_load = 1'b1;
                    if (op_q == OP_ADD) begin
                        if (match_now) begin
                            rsp_err_d  = ERR_DUP;
                            rsp_slot_d = match_idx_now;
                            state_d    = ST_RESP;
                        end else if (!free_now) begin
                            rsp_err_d = ERR_FULL;
                            state_d   = ST_RESP;
                        end else begin
                            rsp_slot_d = free_idx_now;
                            state_d    = gap ? ST_COMMIT : ST_WAITGAP;
                        end
                    end else begin
                        if (!match_now) begin
                            rsp_err_d = ERR_NOTFOUND;
                            state_d   = ST_RESP;
                        end else begin
                            rsp_slot_d = match_idx_now;
                            state_d    = gap ? ST_COMMIT : ST_WAITGAP;
                        end
                    end
                end
            end
            ST_WAITGAP: begin
                if (gap) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                commit  = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            op_q          <= OP_ADD;
            tup_q         <= '0;
            scan_idx_q    <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            rsp_slot_q    <= '0;
            rsp_err_q     <= ERR_OK;
        end else begin
            if (accept) begin
                op_q          <= op_e'(host.cmd_op);
                tup_q         <= cmd_tuple;
                scan_idx_q    <= '0;
                free_found_q  <= 1'b0;
                match_found_q <= 1'b0;
            end else if (state_q == ST_SCAN) begin
                scan_idx_q    <= scan_idx_q + IDX_W'(1);
                free_found_q  <= free_now;
                free_idx_q    <= free_idx_now;
                match_found_q <= match_now;
                match_idx_q   <= match_idx_now;
            end
            if (rsp_load) begin
                rsp_slot_q <= rsp_slot_d;
                rsp_err_q  <= rsp_err_d;
            end
        end
    end

    assign host.cmd_ready = ready && !RESET;
    assign host.rsp_valid = (state_q == ST_RESP);
    assign host.rsp_slot  = host.rsp_valid ? rsp_slot_q : '0;
    assign host.rsp_err   = host.rsp_valid ? rsp_err_q : ERR_OK;

`ifdef TCP_SLOT_HITCNT_EN
    logic [15:0] ent_cnt [SLOTS];
    logic [15:0] cnt_sel;
    logic [15:0] hits_q;

    always_comb begin
        cnt_sel = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (rsp_slot_q == IDX_W'(i)) begin
                cnt_sel = ent_cnt[i];
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            hits_q <= '0;
        end else if (commit) begin
            hits_q <= (op_q == OP_DEL) ? cnt_sel : '0;
        end
    end

    assign rsp_hits = host.rsp_valid ? hits_q : '0;
`endif

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        logic sel;
        assign sel = (rsp_slot_q == IDX_W'(i));

        tcp_slot_entry u_entry (
            .CLOCK     (CLOCK),
            .RESET     (RESET),
            .wr_en     (commit && (op_q == OP_ADD) && sel),
            .clr_en    (commit && ((op_q == OP_FLUSH) || ((op_q == OP_DEL) && sel))),
            .wr_tuple  (tup_q),
            .cmp_tuple (tup_q),
            .en        (ent_en[i]),
            .tuple     (ent_tuple[i]),
            .hit       (ent_hit[i])
`ifdef TCP_SLOT_HITCNT_EN
            ,
            .match_in  (slot_match[i]),
            .cnt_clr   (commit && ((op_q == OP_FLUSH) || ((op_q == OP_ADD) && sel))),
            .hit_cnt   (ent_cnt[i])
`endif
        );

        assign slot_src_ip[32*i +: 32]   = ent_tuple[i].src_ip;
        assign slot_src_port[16*i +: 16] = ent_tuple[i].src_port;
        assign slot_dst_ip[32*i +: 32]   = ent_tuple[i].dst_ip;
        assign slot_dst_port[16*i +: 16] = ent_tuple[i].dst_port;
    end

    assign slot_en = ent_en;

endmodule

// File: tb/tb_tcp_slot_ctrl.sv
// tb_tcp_slot_ctrl
//   Self-checking bench for tcp_slot_ctrl (SLOTS=2). Directed scenarios
//   followed by randomized commands over a small tuple pool with random
//   parser streams; results checked against a table model that applies the
//   command rules directly (lowest match / lowest free slot, first gap).
//   With TCP_SLOT_HITCNT_EN defined the hit counters are exercised too.
module tb_tcp_slot_ctrl;
    import tcp_slot_ctrl_pkg::*;

    localparam int unsigned SLOTS = 2;
    localparam int unsigned IDX_W = 3;

    logic                CLOCK = 1'b0;
    logic                RESET = 1'b1;
    logic                dataValid = 1'b0;
    logic                newpkt = 1'b0;
    logic [SLOTS-1:0]    slot_en;
    logic [SLOTS*32-1:0] slot_src_ip;
    logic [SLOTS*16-1:0] slot_src_port;
    logic [SLOTS*32-1:0] slot_dst_ip;
    logic [SLOTS*16-1:0] slot_dst_port;
`ifdef TCP_SLOT_HITCNT_EN
    logic [SLOTS-1:0]    slot_match = '0;
    logic [15:0]         rsp_hits;
`endif

    tcp_slot_ctrl_if #(.IDX_W(IDX_W)) host_if ();

    tcp_slot_ctrl #(.SLOTS(SLOTS), .IDX_W(IDX_W)) dut (
        .CLOCK         (CLOCK),
        .RESET         (RESET),
        .host          (host_if),
        .dataValid     (dataValid),
        .newpkt        (newpkt),
        .slot_en       (slot_en),
        .slot_src_ip   (slot_src_ip),
        .slot_src_port (slot_src_port),
        .slot_dst_ip   (slot_dst_ip),
        .slot_dst_port (slot_dst_port)
`ifdef TCP_SLOT_HITCNT_EN
        ,
        .slot_match    (slot_match),
        .rsp_hits      (rsp_hits)
`endif
    );

    always #5 CLOCK = ~CLOCK;

    int cyc = 0;
    always @(posedge CLOCK) cyc <= cyc + 1;

    // Parser stream: active in cycles [stream_start, stream_end).
    int stream_start = -1;
    int stream_end   = 0;
    bit stream_dense = 1'b0;
    always @(posedge CLOCK) begin
        #1;
        dataValid = (cyc >= stream_start) && (cyc < stream_end) &&
                    (stream_dense || ($urandom_range(0, 3) != 0));
        newpkt    = (cyc == stream_start) && (stream_end > stream_start);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference table.
    tuple_t mdl_tup [SLOTS];
    bit     mdl_en  [SLOTS];
    int     mdl_cnt [SLOTS];

    task automatic mdl_clear();
        for (int i = 0; i < SLOTS; i++) begin
            mdl_tup[i] = '0;
            mdl_en[i]  = 1'b0;
            mdl_cnt[i] = 0;
        end
    endtask

    task automatic check_table(input string tag);
        logic [SLOTS-1:0]    e_en;
        logic [SLOTS*32-1:0] e_sip, e_dip;
        logic [SLOTS*16-1:0] e_sp, e_dp;
        for (int i = 0; i < SLOTS; i++) begin
            e_en[i]           = mdl_en[i];
            e_sip[i*32 +: 32] = mdl_tup[i].src_ip;
            e_sp[i*16 +: 16]  = mdl_tup[i].src_port;
            e_dip[i*32 +: 32] = mdl_tup[i].dst_ip;
            e_dp[i*16 +: 16]  = mdl_tup[i].dst_port;
        end
        chk({tag, "_en"},    slot_en,       e_en);
        chk({tag, "_sip"},   slot_src_ip,   e_sip);
        chk({tag, "_sport"}, slot_src_port, e_sp);
        chk({tag, "_dip"},   slot_dst_ip,   e_dip);
        chk({tag, "_dport"}, slot_dst_port, e_dp);
    endtask

    task automatic drive_cmd(input logic [1:0] op, input tuple_t t);
        host_if.cmd_valid    = 1'b1;
        host_if.cmd_op       = op;
        host_if.cmd_src_ip   = t.src_ip;
        host_if.cmd_src_port = t.src_port;
        host_if.cmd_dst_ip   = t.dst_ip;
        host_if.cmd_dst_port = t.dst_port;
    endtask

    task automatic idle_cmd();
        host_if.cmd_valid    = 1'b0;
        host_if.cmd_op       = 2'($urandom_range(0, 3));
        host_if.cmd_src_ip   = $urandom();
        host_if.cmd_src_port = 16'($urandom());
        host_if.cmd_dst_ip   = $urandom();
        host_if.cmd_dst_port = 16'($urandom());
    endtask

    // Issue one command with a parser stream of slen cycles starting in the
    // issue cycle, and check response timing/content and table contents.
    task automatic issue(input logic [1:0] op, input tuple_t t, input int slen, input bit dense);
        int   m, f, e_slot, T, R, g, thr, e_R, e_hits;
        logic [1:0] e_err;
        bit   ok, acc, got, gseen;
        m = -1;
        f = -1;
        for (int i = 0; i < SLOTS; i++) begin
            if (m < 0 && mdl_en[i] && mdl_tup[i] == t) m = i;
            if (f < 0 && !mdl_en[i]) f = i;
        end
        ok = 1'b0;
        e_slot = 0;
        e_err = 2'd3;
        case (op)
            2'd0: begin
                if (m >= 0) begin e_err = 2'd1; e_slot = m; end
                else if (f < 0) e_err = 2'd2;
                else begin e_err = 2'd0; e_slot = f; ok = 1'b1; end
            end
            2'd1: begin
                if (m >= 0) begin e_err = 2'd0; e_slot = m; ok = 1'b1; end
            end
            2'd2: begin e_err = 2'd0; ok = 1'b1; end
            default: ;
        endcase
        e_hits = (ok && op == 2'd1) ? mdl_cnt[m] : 0;

        @(posedge CLOCK); #1;
        stream_dense = dense;
        stream_start = cyc;
        stream_end   = cyc + slen;
        drive_cmd(op, t);
        acc = 1'b0;
        T = 0;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge CLOCK);
            if (host_if.cmd_ready) begin
                acc = 1'b1;
                T = cyc;
            end else begin
                @(posedge CLOCK); #1;
            end
        end
        if (!acc) begin
            chk("accept_timeout", 0, 1);
            idle_cmd();
            return;
        end
        thr = (op == 2'd2) ? T : T + SLOTS;
        gseen = 1'b0;
        g = 0;
        if (thr == T && !dataValid && !newpkt) begin
            gseen = 1'b1;
            g = T;
        end
        @(posedge CLOCK); #1;
        idle_cmd();
        got = 1'b0;
        R = 0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge CLOCK);
            if (host_if.rsp_valid) begin
                got = 1'b1;
                R = cyc;
            end else begin
                if (!gseen && cyc >= thr && !dataValid && !newpkt) begin
                    gseen = 1'b1;
                    g = cyc;
                end
                check_table("hold");
            end
        end
        if (!got) begin
            chk("rsp_timeout", 0, 1);
            return;
        end
        if (op == 2'd3)  e_R = T + 1;
        else if (!ok)    e_R = T + SLOTS + 1;
        else             e_R = gseen ? g + 2 : -1;
        chk("rsp_latency", R - T, e_R - T);
        chk("rsp_slot", host_if.rsp_slot, e_slot);
        chk("rsp_err", host_if.rsp_err, e_err);
`ifdef TCP_SLOT_HITCNT_EN
        chk("rsp_hits", rsp_hits, e_hits);
`endif
        if (ok) begin
            case (op)
                2'd0: begin mdl_en[f] = 1'b1; mdl_tup[f] = t; mdl_cnt[f] = 0; end
                2'd1: begin mdl_en[m] = 1'b0; mdl_tup[m] = '0; end
                default: mdl_clear();
            endcase
        end
        check_table("post");
        @(negedge CLOCK);
        chk("rsp_pulse", host_if.rsp_valid, 0);
        chk("ready_after_rsp", host_if.cmd_ready, 1);
    endtask

    tuple_t pool [4];
    bit     rv;

    initial begin
        pool[0] = '{src_ip: 32'h0AD2321C, src_port: 16'd57284, dst_ip: 32'h0AD2900B, dst_port: 16'd4846};
        pool[1] = '{src_ip: 32'h0A000001, src_port: 16'd80,    dst_ip: 32'h0A000002, dst_port: 16'd1234};
        pool[2] = '{src_ip: 32'hC0A80001, src_port: 16'd1000,  dst_ip: 32'hC0A80002, dst_port: 16'd2000};
        pool[3] = '{src_ip: 32'h01020304, src_port: 16'd5,     dst_ip: 32'h05060708, dst_port: 16'd6};
        mdl_clear();
        idle_cmd();

        // Reset state.
        repeat (3) @(posedge CLOCK);
        @(negedge CLOCK);
        chk("reset_ready", host_if.cmd_ready, 0);
        chk("reset_rsp_valid", host_if.rsp_valid, 0);
        chk("reset_rsp_err", host_if.rsp_err, 0);
        check_table("reset");
        @(posedge CLOCK); #1;
        RESET = 1'b0;
        @(negedge CLOCK);
        chk("ready_after_reset", host_if.cmd_ready, 1);

        // Directed table operations.
        issue(2'd0, pool[0], 0, 1'b0);   // ADD A -> slot 0
        issue(2'd0, pool[0], 0, 1'b0);   // dup
        issue(2'd0, pool[1], 0, 1'b0);   // ADD B -> slot 1
        issue(2'd0, pool[2], 0, 1'b0);   // full
        issue(2'd1, pool[0], 0, 1'b0);   // DEL A
        issue(2'd1, pool[0], 0, 1'b0);   // not found
        issue(2'd0, pool[2], 60, 1'b1);  // ADD C during a 60-byte packet
        issue(2'd3, pool[3], 0, 1'b0);   // reserved op

        // Reset while an ADD waits for a gap.
        @(posedge CLOCK); #1;
        stream_dense = 1'b1;
        stream_start = cyc;
        stream_end   = cyc + 40;
        drive_cmd(2'd0, pool[3]);
        @(negedge CLOCK);
        chk("rst_accept", host_if.cmd_ready, 1);
        @(posedge CLOCK); #1;
        idle_cmd();
        repeat (SLOTS + 2) @(posedge CLOCK);
        #1 RESET = 1'b1;
        rv = 1'b0;
        @(negedge CLOCK);
        if (host_if.rsp_valid) rv = 1'b1;
        @(posedge CLOCK); #1;
        RESET = 1'b0;
        @(negedge CLOCK);
        chk("rst_ready", host_if.cmd_ready, 1);
        mdl_clear();
        check_table("rst");
        for (int k = 0; k < 20; k++) begin
            @(negedge CLOCK);
            if (host_if.rsp_valid) rv = 1'b1;
        end
        chk("rst_no_rsp", rv, 0);
        stream_end = cyc;

        // FLUSH of a full table.
        issue(2'd0, pool[0], 0, 1'b0);
        issue(2'd0, pool[1], 0, 1'b0);
        issue(2'd2, pool[3], 8, 1'b0);

`ifdef TCP_SLOT_HITCNT_EN
        issue(2'd0, pool[0], 0, 1'b0);
        @(posedge CLOCK); #1;
        slot_match[0] = 1'b1;
        repeat (5) @(posedge CLOCK);
        #1 slot_match[0] = 1'b0;
        mdl_cnt[0] = mdl_cnt[0] + 5;
        issue(2'd1, pool[0], 0, 1'b0);
        issue(2'd0, pool[0], 0, 1'b0);
        @(posedge CLOCK); #1;
        slot_match[0] = 1'b1;
        repeat (70000) @(posedge CLOCK);
        #1 slot_match[0] = 1'b0;
        mdl_cnt[0] = (mdl_cnt[0] + 70000 > 65535) ? 65535 : mdl_cnt[0] + 70000;
        issue(2'd1, pool[0], 0, 1'b0);
`endif

        // Randomized commands.
        for (int n = 0; n < 60; n++) begin
            int unsigned r;
            logic [1:0]  op;
            r = $urandom_range(0, 99);
            if (r < 45)      op = 2'd0;
            else if (r < 80) op = 2'd1;
            else if (r < 92) op = 2'd2;
            else             op = 2'd3;
            issue(op, pool[$urandom_range(0, 3)], int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
